decode_issue: RTL and testbench
===============================

# decode_issue

Decode/issue stage directly upstream of the ALU. Accepts one 16-bit instruction word per cycle over a valid/ready handshake, decodes it into the ALU's 8-bit opcode, and reads both operands from a 16×16 register file. It drives `opcode`, `rdataA` and `rdataB` into the ALU, then writes the ALU's registered `result` back into the destination register. It also contains the hazard and stall logic that keeps read-after-write ordering correct across the ALU's one-cycle latency.

## Interface
- WIDTH, 16, datapath width; only 16 is supported
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- inst  in  16  instruction word: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc (or [7:0] imm)
- inst_valid  in  1  `inst` is presented
- inst_ready  out  1  stage can accept `inst` this cycle
- alu_result  in  16  ALU `result`, valid one cycle after issue
- opcode  out  8  ALU opcode (registered)
- rdataA  out  16  operand A, R[Rdest] (registered)
- rdataB  out  16  operand B, R[Rsrc] or extended immediate (registered)

## Operation
Decode rules:
- op 0000, 0100, 1000 with ext 0100: register form.
  - opcode = {op, ext}; A = R[Rdest]; B = R[Rsrc].
- op 1000, other ext: shift-immediate.
  - opcode = {1000, 000, inst[4]}; B = {12'b0, inst[3:0]}.
- op 0001, 0010, 0011: ANDI/ORI/XORI.
  - opcode = {0000, op}; B = zero-extended inst[7:0].
- op 0101, 0110, 1001, 1011, 1101: ADDI/ADDUI/SUBI/CMPI/MOVI.
  - opcode = {0000, op}; B = sign-extended inst[7:0].
- op 1111: LUI. opcode = 8'hF0; B = {8'b0, inst[7:0]}.
- Any other op: issued as bubble.

Write-enable (we):
- Set for opcodes 01, 02, 03, 05, 06, 09, 0D, 4F, 80, 81, 84, F0.
- Clear for CMP (0B), STORE (44), LOAD (40) and bubbles. The memory stage owns load data.

Pipeline slots (registered per clock):
- S1: instruction issued this edge; the ALU computes it at the next edge.
- S2: `alu_result` holds its value. R[dest] is written at the next edge when we = 1.
- Each edge: S2 retires (write), S1 moves to S2, and the accepted instruction (or a bubble) enters S1.

Hazard:
- An instruction depends on a slot when the slot has we = 1 and its dest equals Rdest (always a source) or Rsrc (register form only).
- inst_ready = 0 while any dependency blocks issue. The rules are under Configuration.
- On a stall, or when inst_valid = 0: opcode = 8'h00, and rdataA/rdataB hold their last values. A bubble enters S1 with we = 0.
- An instruction is accepted only when inst_valid and inst_ready are both 1 at the edge.

Register file:
- R0–R15 are all general purpose; R0 is writable.
- The S2 write and the S1 capture happen on the same edge.

## Timing
- Accept at edge N → opcode/operands valid after N.
- ALU result is valid after N+1.
- R[dest] is updated at edge N+2 and visible to a read captured at edge N+3 or later. The FWD_EN bypass lets a read use it one cycle earlier.
- inst_ready is combinational from inst, S1 and S2.

Reset (reset = 0 at an edge):
- All registers cleared to 0: R0–R15, opcode, rdataA, rdataB.
- S1 and S2 invalidated (we = 0). A pending write is discarded.
- inst_ready = 1 from the first edge after reset deasserts.

Boundary cases:
- Dependency on both S1 and S2: S1 governs. Stall, then resolve S2 by the normal rule.
- Back-to-back writes to the same Rdest: the younger write wins.
- The sign-extension boundary is inst[7]: imm 8'h80 → 16'hFF80.

## Configuration
FWD_EN:
- Defined:
  - A dependency on S2 is resolved by forwarding `alu_result` into the captured operand.
  - A dependency on S1 stalls for 1 cycle.
- Undefined:
  - Any dependency on S1 or S2 stalls. A dependent instruction waits up to 2 cycles.
  - No bypass path exists.

## Test plan
- Reset then MOVI R1,#5 (0xD105) → opcode 0D, B = 0005; R1 = 0005 at edge N+2.
- ADDI R2,#0x80 (0x5280) → opcode 05, B = FF80; ANDI R2,#0x80 (0x1280) → B = 0080.
- MOVI R1,#3 then ADD R1,R1 (0x0151) back-to-back:
  - with FWD_EN: inst_ready low 1 cycle, rdataA = rdataB = 0003 from forwarding;
  - without: low 2 cycles, R1 read from the file = 0003.
- CMPI R4,#7 followed by ADD R4,R4 → no stall; R4 unchanged.
- LUI R5,#0x12 (0xF512), then reset = 0 at edge N+1 → R5 stays 0000, opcode 00.
- Continuous inst_valid with independent registers → one issue per cycle, inst_ready held at 1.

Source files
------------

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
//
// Decode/issue stage sitting directly in front of the ALU. One 16-bit
// instruction is accepted per cycle over a valid/ready handshake. It is
// decoded into the ALU's 8-bit opcode, and both operands are read from a
// 16 x 16 register file. The ALU result comes back one cycle after issue
// and is written into the destination register on the following edge.
// Read-after-write hazards across that latency are handled here by stalling
// inst_ready.
//
// Optional feature macro: FWD_EN
//   defined   - a dependency on the retiring slot (S2) is served by
//               forwarding alu_result into the captured operand. Only a
//               dependency on S1 stalls, and it stalls for one cycle.
//   undefined - any dependency on S1 or S2 stalls. There is no bypass path.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   inst        in   instruction: [15:12] op, [11:8] Rdest, [7:4] ext,
//                    [3:0] Rsrc (or [7:0] imm)
//   inst_valid  in   inst is presented
//   inst_ready  out  stage can accept inst this cycle (combinational)
//   alu_result  in   ALU result, valid one cycle after issue
//   opcode      out  registered ALU opcode (8'h00 = bubble)
//   rdataA      out  registered operand A = R[Rdest]
//   rdataB      out  registered operand B = R[Rsrc] or extended immediate
// -----------------------------------------------------------------------------
module decode_issue #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      inst,
   input  logic             inst_valid,
   output logic             inst_ready,
   input  logic [WIDTH-1:0] alu_result,
   output logic [7:0]       opcode,
   output logic [WIDTH-1:0] rdataA,
   output logic [WIDTH-1:0] rdataB
);

   // Instruction format classes.
   typedef enum logic [1:0] {
      FmtBubble,
      FmtReg,
      FmtImm
   } fmt_e;

   // ---------------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------------
   logic [3:0] op;
   logic [3:0] rd;
   logic [3:0] ext;
   logic [3:0] rs;
   logic [7:0] imm8;

   assign op   = inst[15:12];
   assign rd   = inst[11:8];
   assign ext  = inst[7:4];
   assign rs   = inst[3:0];
   assign imm8 = inst[7:0];

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] rf_q [16];
   logic [WIDTH-1:0] rf_d [16];

   // S1: issued last edge, the ALU is computing it now.
   // S2: alu_result currently holds its value, and it retires next edge.
   logic       s1_we_q,   s1_we_d;
   logic [3:0] s1_dest_q, s1_dest_d;
   logic       s2_we_q,   s2_we_d;
   logic [3:0] s2_dest_q, s2_dest_d;

   logic [7:0]       opcode_q,  opcode_d;
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   fmt_e             dec_fmt;
   logic [7:0]       dec_opcode;
   logic [WIDTH-1:0] dec_imm;
   logic             dec_we;
   logic             dec_is_reg;
   logic             dec_valid;

   always_comb begin : decode
      dec_fmt    = FmtBubble;
      dec_opcode = 8'h00;
      dec_imm    = '0;
      case (op)
         // Register form. The ext field is the ALU sub-opcode.
         4'b0000, 4'b0100: begin
            dec_fmt    = FmtReg;
            dec_opcode = {op, ext};
         end
         // Op 1000 is a register shift only for ext 0100. Otherwise it is a
         // shift by a 4-bit immediate, and inst[4] picks the direction.
         4'b1000: begin
            if (ext == 4'b0100) begin
               dec_fmt    = FmtReg;
               dec_opcode = {op, ext};
            end else begin
               dec_fmt    = FmtImm;
               dec_opcode = {4'b1000, 3'b000, inst[4]};
               dec_imm    = {{(WIDTH-4){1'b0}}, rs};
            end
         end
         // ANDI / ORI / XORI: logical ops take a zero-extended immediate.
         4'b0001, 4'b0010, 4'b0011: begin
            dec_fmt    = FmtImm;
            dec_opcode = {4'b0000, op};
            dec_imm    = {{(WIDTH-8){1'b0}}, imm8};
         end
         // ADDI / ADDUI / SUBI / CMPI / MOVI: arithmetic ops take a
         // sign-extended immediate.
         4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b1101: begin
            dec_fmt    = FmtImm;
            dec_opcode = {4'b0000, op};
            dec_imm    = {{(WIDTH-8){imm8[7]}}, imm8};
         end
         // LUI: the ALU does the shift, so the immediate goes out unshifted.
         4'b1111: begin
            dec_fmt    = FmtImm;
            dec_opcode = 8'hF0;
            dec_imm    = {{(WIDTH-8){1'b0}}, imm8};
         end
         default: begin
            dec_fmt = FmtBubble;
         end
      endcase
   end

   assign dec_is_reg = (dec_fmt == FmtReg);
   assign dec_valid  = (dec_fmt != FmtBubble);

   // Only opcodes that produce a register result write back. CMP/CMPI,
   // LOAD and STORE do not: load data belongs to the memory stage.
   always_comb begin : write_enable
      dec_we = 1'b0;
      case (dec_opcode)
         8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0D,
         8'h4F, 8'h80, 8'h81, 8'h84, 8'hF0: dec_we = 1'b1;
         default:                           dec_we = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   // Rdest is always read as operand A. Rsrc is read only in register form.
   logic dep_s1;
   logic dep_s2;
   logic stall;
   logic fwd_a;
   logic fwd_b;
   logic accept;

   assign dep_s1 = dec_valid && s1_we_q &&
                   ((s1_dest_q == rd) || (dec_is_reg && (s1_dest_q == rs)));
   assign dep_s2 = dec_valid && s2_we_q &&
                   ((s2_dest_q == rd) || (dec_is_reg && (s2_dest_q == rs)));

`ifdef FWD_EN
   // alu_result already holds S2's value, so an S2 dependency is bypassed.
   // S1 governs when both slots match. After one stall cycle the old S1 has
   // moved to S2 and is then forwarded.
   assign stall = dep_s1;
   assign fwd_a = s2_we_q && (s2_dest_q == rd);
   assign fwd_b = s2_we_q && dec_is_reg && (s2_dest_q == rs);
`else
   // The S2 write lands on the same edge as the operand capture, so an S2
   // dependency also waits until the file holds the value.
   assign stall = dep_s1 || dep_s2;
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   assign inst_ready = !stall;
   assign accept     = inst_valid && inst_ready;

   // ---------------------------------------------------------------------------
   // Operand selection
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   always_comb begin : operands
      op_a = rf_q[rd];
      op_b = dec_imm;
      if (fwd_a) begin
         op_a = alu_result;
      end
      if (dec_is_reg) begin
         op_b = fwd_b ? alu_result : rf_q[rs];
      end
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin : next_state
      // Retire S2 into the register file.
      rf_d = rf_q;
      if (s2_we_q) begin
         rf_d[s2_dest_q] = alu_result;
      end

      // Advance the slots. A stall, an idle cycle or an undecodable op
      // enters S1 as a bubble.
      s2_we_d   = s1_we_q;
      s2_dest_d = s1_dest_q;
      s1_we_d   = accept && dec_we;
      s1_dest_d = rd;

      opcode_d  = accept ? dec_opcode : 8'h00;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      if (accept && dec_valid) begin
         rdata_a_d = op_a;
         rdata_b_d = op_b;
      end
   end

   always_ff @(posedge clock) begin : state_regs
      if (!reset) begin
         rf_q      <= '{default: '0};
         s1_we_q   <= 1'b0;
         s1_dest_q <= 4'd0;
         s2_we_q   <= 1'b0;
         s2_dest_q <= 4'd0;
         opcode_q  <= 8'h00;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         rf_q      <= rf_d;
         s1_we_q   <= s1_we_d;
         s1_dest_q <= s1_dest_d;
         s2_we_q   <= s2_we_d;
         s2_dest_q <= s2_dest_d;
         opcode_q  <= opcode_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   assign opcode = opcode_q;
   assign rdataA = rdata_a_q;
   assign rdataB = rdata_b_q;

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
//
// Table-driven bench for decode_issue. Each table row is one clock cycle. It
// gives the instruction presented, the inst_ready expected before the edge,
// and the opcode/rdataA/rdataB expected after it. A small behavioural ALU
// stands in for the real one and produces alu_result one cycle after issue.
// Register contents are observed through rdataA (operand A = R[Rdest]).
// Rows covering a stall differ with FWD_EN and are selected the same way.
// -----------------------------------------------------------------------------
module tb_decode_issue;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] inst = 16'h0000;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [15:0] alu_result = 16'h0000;
   logic [7:0]  opcode;
   logic [15:0] rdataA;
   logic [15:0] rdataB;

   always #5 clock = ~clock;

   decode_issue #(
      .WIDTH(16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .alu_result (alu_result),
      .opcode     (opcode),
      .rdataA     (rdataA),
      .rdataB     (rdataB)
   );

   // Behavioural ALU with one cycle of latency.
   always @(posedge clock) begin
      case (opcode)
         8'h01:   alu_result <= rdataA & rdataB;
         8'h02:   alu_result <= rdataA | rdataB;
         8'h03:   alu_result <= rdataA ^ rdataB;
         8'h05:   alu_result <= rdataA + rdataB;
         8'h0B:   alu_result <= rdataA - rdataB;
         8'h0D:   alu_result <= rdataB;
         8'h81:   alu_result <= rdataA >> rdataB[3:0];
         8'hF0:   alu_result <= rdataB << 8;
         default: alu_result <= 16'h0000;
      endcase
   end

   typedef struct {
      logic [15:0] inst;
      logic        valid;
      logic        rdy;
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void add(input logic [15:0] i, input logic v, input logic r,
                               input logic [7:0] o, input logic [15:0] a,
                               input logic [15:0] b);
      vec_t t;
      t.inst  = i;
      t.valid = v;
      t.rdy   = r;
      t.op    = o;
      t.a     = a;
      t.b     = b;
      vecs.push_back(t);
   endfunction

   task automatic check(input string what, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", what, act, exp);
      end
   endtask

   // Entered just after a rising edge. Drives the row, checks ready at the
   // falling edge, then checks the registered outputs just after the next
   // rising edge.
   task automatic run_row(input string tag, input vec_t v);
      inst       = v.inst;
      inst_valid = v.valid;
      @(negedge clock);
      check({tag, " ready"}, {15'b0, inst_ready}, {15'b0, v.rdy});
      @(posedge clock);
      #1;
      check({tag, " opcode"}, {8'h00, opcode}, {8'h00, v.op});
      check({tag, " rdataA"}, rdataA, v.a);
      check({tag, " rdataB"}, rdataB, v.b);
   endtask

   initial begin
      vec_t post;

      //   inst     v     rdy   op     A         B
      add(16'hD105, 1'b1, 1'b1, 8'h0D, 16'h0000, 16'h0005); // MOVI R1,#5
      add(16'h5280, 1'b1, 1'b1, 8'h05, 16'h0000, 16'hFF80); // ADDI R2,#80 sign-ext
      add(16'h1380, 1'b1, 1'b1, 8'h01, 16'h0000, 16'h0080); // ANDI R3,#80 zero-ext
      add(16'h0000, 1'b0, 1'b1, 8'h00, 16'h0000, 16'h0080); // idle: operands hold
      add(16'h2100, 1'b1, 1'b1, 8'h02, 16'h0005, 16'h0000); // ORI R1: R1 = 5
      add(16'h320F, 1'b1, 1'b1, 8'h03, 16'hFF80, 16'h000F); // XORI R2: R2 = FF80
      add(16'h0000, 1'b0, 1'b1, 8'h00, 16'hFF80, 16'h000F);
      add(16'h0000, 1'b0, 1'b1, 8'h00, 16'hFF80, 16'h000F);
      add(16'hD103, 1'b1, 1'b1, 8'h0D, 16'h0005, 16'h0003); // MOVI R1,#3
      add(16'h0151, 1'b1, 1'b0, 8'h00, 16'h0005, 16'h0003); // ADD R1,R1: S1 stall
`ifdef FWD_EN
      add(16'h0151, 1'b1, 1'b1, 8'h05, 16'h0003, 16'h0003); // forwarded from S2
      add(16'h0000, 1'b0, 1'b1, 8'h00, 16'h0003, 16'h0003);
`else
      add(16'h0151, 1'b1, 1'b0, 8'h00, 16'h0005, 16'h0003); // S2 stall
      add(16'h0151, 1'b1, 1'b1, 8'h05, 16'h0003, 16'h0003); // read from file
`endif
      add(16'hB407, 1'b1, 1'b1, 8'h0B, 16'h0000, 16'h0007); // CMPI R4,#7
      add(16'h0454, 1'b1, 1'b1, 8'h05, 16'h0000, 16'h0000); // ADD R4,R4: no stall
      add(16'h2100, 1'b1, 1'b1, 8'h02, 16'h0006, 16'h0000); // ORI R1: R1 = 6
      add(16'h0000, 1'b0, 1'b1, 8'h00, 16'h0006, 16'h0000);
      add(16'h8213, 1'b1, 1'b1, 8'h81, 16'hFF8F, 16'h0003); // shift imm, R2 = FF8F
      add(16'h7123, 1'b1, 1'b1, 8'h00, 16'hFF8F, 16'h0003); // undefined op: bubble
      add(16'hD801, 1'b1, 1'b1, 8'h0D, 16'h0000, 16'h0001); // back-to-back issue
      add(16'hD902, 1'b1, 1'b1, 8'h0D, 16'h0000, 16'h0002);
      add(16'hDA03, 1'b1, 1'b1, 8'h0D, 16'h0000, 16'h0003);
      add(16'hDB04, 1'b1, 1'b1, 8'h0D, 16'h0000, 16'h0004);
      add(16'h2800, 1'b1, 1'b1, 8'h02, 16'h0001, 16'h0000);
      add(16'h2900, 1'b1, 1'b1, 8'h02, 16'h0002, 16'h0000);
      add(16'h2A00, 1'b1, 1'b1, 8'h02, 16'h0003, 16'h0000);
      add(16'h2B00, 1'b1, 1'b1, 8'h02, 16'h0004, 16'h0000);
      add(16'hF512, 1'b1, 1'b1, 8'hF0, 16'h0000, 16'h0012); // LUI R5,#12

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("reset opcode", {8'h00, opcode}, 16'h0000);
      check("reset rdataA", rdataA, 16'h0000);
      check("reset rdataB", rdataB, 16'h0000);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_row($sformatf("row%0d", i), vecs[i]);
      end

      // Reset on the edge after LUI issues: its write must be discarded.
      reset      = 1'b0;
      inst_valid = 1'b0;
      @(posedge clock);
      #1;
      check("midreset opcode", {8'h00, opcode}, 16'h0000);
      check("midreset rdataA", rdataA, 16'h0000);
      check("midreset rdataB", rdataB, 16'h0000);
      reset = 1'b1;

      post = '{inst: 16'h2500, valid: 1'b1, rdy: 1'b1, op: 8'h02, a: 16'h0000, b: 16'h0000};
      run_row("post R5", post);
      post = '{inst: 16'h3200, valid: 1'b1, rdy: 1'b1, op: 8'h03, a: 16'h0000, b: 16'h0000};
      run_row("post R2", post);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
